inst_loader: RTL

- Writer side of the processor's instruction store. The core fetches 24-bit instructions by PC address; this block fills that store.
- Accepts a byte stream over a valid/ready handshake and assembles three bytes, MSB first, into one 24-bit instruction word.
- Writes each word at sequential addresses starting from 0, then signals completion so the core can be released from reset.

---
 rtl/nibble_pkg.sv | 44 ++++
 rtl/byte_assembler.sv | 42 ++++
 rtl/inst_loader.sv | 130 +++++++++++++
 3 files changed

// File: rtl/nibble_pkg.sv
// Shared definitions for the 24-bit instruction format, used by both the
// core decoder and the instruction loader.
package nibble_pkg;

  localparam int INST_W = 24;

  localparam int RSV_BIT = 23;
  localparam int OP_LSB = 20;
  localparam int OP_W = 3;
  localparam int X_LSB = 12;
  localparam int X_W = 8;
  localparam int Y_LSB = 4;
  localparam int Y_W = 8;
  localparam int ADDR_LSB = 0;
  localparam int ADDR_FLD_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } loader_state_t;

  function automatic logic inst_reserved(input logic [INST_W-1:0] w);
    return w[RSV_BIT];
  endfunction

  function automatic logic [OP_W-1:0] inst_op(input logic [INST_W-1:0] w);
    return w[OP_LSB +: OP_W];
  endfunction

  function automatic logic [X_W-1:0] inst_x(input logic [INST_W-1:0] w);
    return w[X_LSB +: X_W];
  endfunction

  function automatic logic [Y_W-1:0] inst_y(input logic [INST_W-1:0] w);
    return w[Y_LSB +: Y_W];
  endfunction

  function automatic logic [ADDR_FLD_W-1:0] inst_addr(input logic [INST_W-1:0] w);
    return w[ADDR_LSB +: ADDR_FLD_W];
  endfunction

endpackage

// File: rtl/byte_assembler.sv
// Shifts bytes MSB-first into a word and flags the byte that completes it.
// word_valid and next_word are combinational so the caller can act on the
// completing transfer in the same cycle.
module byte_assembler #(
  parameter int WORD_BYTES = 3,
  parameter int CNT_W = $clog2(WORD_BYTES)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    shift_en,
  input  logic [7:0]              data,
  output logic [WORD_BYTES*8-1:0] next_word,
  output logic                    word_valid
);

  localparam int WORD_W = WORD_BYTES * 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_BYTES - 1);

  logic [WORD_W-1:0] word_p0;
  logic [CNT_W-1:0]  byte_cnt;

  assign next_word  = {word_p0[WORD_W-9:0], data};
  assign word_valid = shift_en && (byte_cnt == CNT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_p0  <= '0;
      byte_cnt <= '0;
    end else begin
      if (clr) begin
        byte_cnt <= '0;
      end else if (shift_en) begin
        byte_cnt <= word_valid ? '0 : byte_cnt + CNT_W'(1);
      end
      if (shift_en) begin
        word_p0 <= next_word;
      end
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Fills the instruction store from a byte stream: three bytes per word, MSB
// first, written at sequential addresses from 0, then reports done.
module inst_loader
  import nibble_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DEPTH = 16,
  parameter int WORD_BYTES = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [INST_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W + 1)'(DEPTH - 1);

  loader_state_t     state;
  logic              xfer;
  logic              load_start;
  logic              word_valid;
  logic [INST_W-1:0] next_word;
  logic              last_p1;
  logic              full_slot;

  // The address saturates on the final slot so a full memory never wraps.
  function automatic logic [ADDR_W-1:0] addr_advance(input logic [ADDR_W-1:0] a,
                                                      input logic at_end);
    return at_end ? a : a + ADDR_W'(1);
  endfunction

  assign xfer       = in_valid && in_ready;
  assign load_start = start && ((state == IDLE) || (state == DONE));
  assign full_slot  = (word_count == LAST_SLOT);

  byte_assembler #(
    .WORD_BYTES(WORD_BYTES)
  ) u_asm (
    .clock     (clock),
    .reset     (reset),
    .clr       (load_start),
    .shift_en  (xfer),
    .data      (in_data),
    .next_word (next_word),
    .word_valid(word_valid)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
      last_p1    <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RECV;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            mem_addr   <= '0;
            word_count <= '0;
          end
        end
        RECV: begin
          if (xfer) begin
            if (word_valid) begin
              state     <= WRITE;
              in_ready  <= 1'b0;
              mem_we    <= 1'b1;
              mem_wdata <= next_word;
              last_p1   <= in_last;
              if (inst_reserved(next_word)) begin
                err <= 1'b1;
              end
            end else if (in_last) begin
              // Program ended mid-word: drop the partial word.
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              err      <= 1'b1;
            end
          end
        end
        WRITE: begin
          word_count <= word_count + (ADDR_W + 1)'(1);
          mem_addr   <= addr_advance(mem_addr, full_slot);
          if (last_p1 || full_slot) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (!last_p1) begin
              err <= 1'b1;
            end
          end else begin
            state    <= RECV;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule
